// File: rtl/affine_tap_window.sv
// affine_tap_window: builds a sliding 6-sample window over a row of reference
// samples and presents each full window as six registered tap operands for the
// affine interpolation multiplier blocks (out_tapk feeds the tap-k MCM X input).
// Optional feature macro: AFFINE_TAP_ERRCNT_EN adds a saturating 8-bit
// row-error counter on port err_cnt.

module affine_tap_window #(
    parameter int DATA_W  = 32,
    parameter int ROW_LEN = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_tap0,
    output logic [DATA_W-1:0] out_tap1,
    output logic [DATA_W-1:0] out_tap2,
    output logic [DATA_W-1:0] out_tap3,
    output logic [DATA_W-1:0] out_tap4,
    output logic [DATA_W-1:0] out_tap5,
    output logic              out_last,
`ifdef AFFINE_TAP_ERRCNT_EN
    output logic [7:0]        err_cnt,
`endif
    output logic              row_err
);

    // Index of the final sample position in a row.
    localparam logic [7:0] LAST_IDX = 8'(ROW_LEN - 1);
    // First index at which five older samples are available.
    localparam logic [7:0] FULL_IDX = 8'd5;

    logic [7:0]        idx_r;
    logic [DATA_W-1:0] hist_r [5];   // hist_r[4] newest accepted sample
    logic [DATA_W-1:0] tap_r  [6];
    logic              out_valid_r;
    logic              out_last_r;
    logic              row_err_r;

    logic              in_ready_s;
    logic              accept_s;
    logic              at_end_s;
    logic              end_s;
    logic              emit_s;
    logic              err_s;

    // Handshake decode: accept, end-of-row, window emit and row-length check.
    always_comb begin
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        at_end_s   = 1'b0;
        end_s      = 1'b0;
        emit_s     = 1'b0;
        err_s      = 1'b0;
        in_ready_s = (!out_valid_r) || out_ready;
        accept_s   = in_valid && in_ready_s;
        at_end_s   = (idx_r == LAST_IDX);
        if (accept_s) begin
            end_s  = in_last || at_end_s;
            emit_s = (idx_r >= FULL_IDX);
            err_s  = (in_last != at_end_s);
        end else begin
            end_s  = 1'b0;
            emit_s = 1'b0;
            err_s  = 1'b0;
        end
    end

    // Sample history, row index, output window register and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r       <= 8'd0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            row_err_r   <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                hist_r[i] <= {DATA_W{1'b0}};
            end
            for (int i = 0; i < 6; i++) begin
                tap_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            row_err_r <= err_s;
            if (accept_s) begin
                for (int i = 0; i < 4; i++) begin
                    hist_r[i] <= hist_r[i+1];
                end
                hist_r[4] <= in_data;
                // A closed row restarts at index 0 so old history never reaches a window.
                idx_r <= end_s ? 8'd0 : (idx_r + 8'd1);
            end else begin
                idx_r <= idx_r;
            end
            if (emit_s) begin
                for (int i = 0; i < 5; i++) begin
                    tap_r[i] <= hist_r[i];
                end
                tap_r[5]    <= in_data;
                out_last_r  <= end_s;
                out_valid_r <= 1'b1;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

`ifdef AFFINE_TAP_ERRCNT_EN
    logic [7:0] err_cnt_r;

    // Saturating count of row-length violations, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 8'd0;
        end else if (row_err_r && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign row_err   = row_err_r;
    assign out_tap0  = tap_r[0];
    assign out_tap1  = tap_r[1];
    assign out_tap2  = tap_r[2];
    assign out_tap3  = tap_r[3];
    assign out_tap4  = tap_r[4];
    assign out_tap5  = tap_r[5];

endmodule

// File: tb/tb_affine_tap_window.sv
// Testbench for affine_tap_window (ROW_LEN=9, DATA_W=32).
// Table of sample records with expected window/err flags feeds a scoreboard
// queue; a monitor thread pops and compares every delivered window.

module tb_affine_tap_window;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_tap0, out_tap1, out_tap2, out_tap3, out_tap4, out_tap5;
    logic        out_last;
    logic        row_err;
`ifdef AFFINE_TAP_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    affine_tap_window #(.DATA_W(32), .ROW_LEN(9)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tap0(out_tap0), .out_tap1(out_tap1), .out_tap2(out_tap2),
        .out_tap3(out_tap3), .out_tap4(out_tap4), .out_tap5(out_tap5),
        .out_last(out_last),
`ifdef AFFINE_TAP_ERRCNT_EN
        .err_cnt(err_cnt),
`endif
        .row_err(row_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        bit          emit;
        int          base;
        bit          olast;
        bit          err;
    } vec_t;

    typedef struct packed {
        logic [5:0][31:0] t;
        logic             last;
    } win_t;

    vec_t vec[$];
    win_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_err = 0;
    int   err_seen = 0;
    int   stall_seen = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Row of n samples starting at 'start'; give_last puts in_last on the final one.
    function automatic void add_row(input int start, input int n, input bit give_last);
        vec_t v;
        for (int p = 0; p < n; p++) begin
            v.data  = 32'(start + p);
            v.last  = give_last && (p == n - 1);
            v.emit  = (p >= 5);
            v.base  = start + p - 5;
            v.olast = v.emit && (p == n - 1);
            v.err   = (p == n - 1) && !(give_last && n == 9);
            vec.push_back(v);
        end
    endfunction

    function automatic win_t mk_win(input int base, input bit last);
        win_t w;
        for (int k = 0; k < 6; k++) w.t[k] = 32'(base + k);
        w.last = last;
        return w;
    endfunction

    task automatic send(input logic [31:0] d, input logic l);
        int w;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        w = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 100) begin
                chk(1'b0, "in_ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (vec[i].emit) exp_q.push_back(mk_win(vec[i].base, vec[i].olast));
            if (vec[i].err) exp_err++;
            send(vec[i].data, vec[i].last);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain_check(input string name);
        repeat (4) @(posedge clk);
        #1;
        chk(exp_q.size() == 0, {name, "_windows_left"}, exp_q.size(), 0);
        chk(err_seen == exp_err, {name, "_row_err_count"}, err_seen, exp_err);
    endtask

    task automatic monitor();
        win_t act, held;
        bit   prev_stall;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            act.t = {out_tap5, out_tap4, out_tap3, out_tap2, out_tap1, out_tap0};
            act.last = out_last;
            if (row_err) err_seen++;
            if (prev_stall && out_valid)
                chk(act == held, "hold_stable", $signed(out_tap0), $signed(held.t[0]));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_window", $signed(out_tap0), 0);
                end else begin
                    win_t e;
                    e = exp_q.pop_front();
                    n_tests++;
                    if (act != e) begin
                        n_fail++;
                        $display("FAIL window: got tap0..5 %0d %0d %0d %0d %0d %0d last %0b, required tap0 %0d..%0d last %0b",
                                 $signed(out_tap0), $signed(out_tap1), $signed(out_tap2), $signed(out_tap3),
                                 $signed(out_tap4), $signed(out_tap5), out_last,
                                 $signed(e.t[0]), $signed(e.t[5]), e.last);
                    end
                end
            end
            if (out_valid && !out_ready) begin
                stall_seen++;
                chk(in_ready == 1'b0, "in_ready_during_stall", in_ready, 0);
                held = act;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
        end
    endtask

    initial begin
        int t1, t2, t3, t4, t7, t_end;
        rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0; out_ready = 1'b1;

        // Stimulus table
        t1 = vec.size(); add_row(1, 9, 1'b1);
        t2 = vec.size(); add_row(1, 9, 1'b1);
        t3 = vec.size(); add_row(101, 4, 1'b1); add_row(11, 9, 1'b1);
        t4 = vec.size(); add_row(31, 9, 1'b0); add_row(40, 9, 1'b1);
        t7 = vec.size(); add_row(-20, 9, 1'b1);
        t_end = vec.size();

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        // Reset state
        chk(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
        chk(out_last == 1'b0, "reset_out_last", out_last, 0);
        chk(row_err == 1'b0, "reset_row_err", row_err, 0);
        chk(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
        chk({out_tap0, out_tap1, out_tap2, out_tap3, out_tap4, out_tap5} == 192'd0, "reset_taps", out_tap0, 0);
`ifdef AFFINE_TAP_ERRCNT_EN
        chk(err_cnt == 8'd0, "reset_err_cnt", err_cnt, 0);
`endif

        // 1: conforming row, free-running consumer
        run_vecs(t1, t2);
        drain_check("t1");

        // 2: consumer stalls 3 cycles after the first window
        fork
            begin : stall_thr
                int w;
                w = 0;
                while (!out_valid && w < 60) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join_none
        run_vecs(t2, t3);
        drain_check("t2");
        chk(stall_seen >= 3, "t2_stall_observed", stall_seen, 3);

        // 3: short row then conforming row; 4: missing in_last then next row
        run_vecs(t3, t4);
        drain_check("t3");
        run_vecs(t4, t7);
        drain_check("t4");

        // 5: reset after 7 accepted samples of row 51..57
        for (int p = 0; p < 7; p++) begin
            if (p == 5) exp_q.push_back(mk_win(51, 1'b0));
            send(32'(51 + p), 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        chk(out_valid == 1'b0, "t5_out_valid_after_rst", out_valid, 0);
        chk(out_last == 1'b0, "t5_out_last_after_rst", out_last, 0);
        chk(out_tap5 == 32'd0, "t5_tap5_after_rst", out_tap5, 0);
        vec.push_back('{data: 32'd0, last: 1'b0, emit: 1'b0, base: 0, olast: 1'b0, err: 1'b0});
        add_row(21, 9, 1'b1);
        run_vecs(t_end + 1, vec.size());
        drain_check("t5");

        // signed samples pass bit-exact
        run_vecs(t7, t_end);
        drain_check("t7");

        // 6: 300 one-sample rows closed early
        for (int r = 0; r < 300; r++) begin
            exp_err++;
            send(32'(1000 + r), 1'b1);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        drain_check("t6");
`ifdef AFFINE_TAP_ERRCNT_EN
        chk(err_cnt == 8'd255, "t6_err_cnt_saturated", err_cnt, 255);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
